// File: rtl/typing_round_ctrl.sv
// Round FSM for the typing tutor: arms/clears the countdown timer, judges keys, keeps score, misses, level and lives.
// Latency: one state step per cycle with Moore outputs; no backpressure, keystrokes count only in RUN.
module typing_round_ctrl #(
    parameter int BASE_LIMIT     = 10,
    parameter int MIN_LIMIT      = 3,
    parameter int HITS_PER_LEVEL = 5,
    parameter int LIVES          = 3,
    parameter int MAX_LEVEL      = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic [7:0] target_code,
    input  logic [3:0] newTime,
    output logic       timer_clear,
    output logic       timer_en,
    output logic [3:0] currTimeLimit,
    output logic       char_req,
    output logic [7:0] score,
    output logic [7:0] misses,
    output logic [2:0] level,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        HIT     = 3'd3,
        TIMEOUT = 3'd4,
        OVER    = 3'd5
    } state_t;

    localparam logic [3:0] BASE4      = 4'(BASE_LIMIT);
    localparam logic [3:0] MIN4       = 4'(MIN_LIMIT);
    localparam logic [7:0] HPL        = 8'(HITS_PER_LEVEL);
    localparam logic [2:0] MAXL       = 3'(MAX_LEVEL);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    state_t     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic [7:0] misses_q, misses_d;
    logic [7:0] streak_q, streak_d;
    logic [2:0] level_q, level_d;
    logic [1:0] lives_q, lives_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            score_q  <= 8'd0;
            misses_q <= 8'd0;
            streak_q <= 8'd0;
            level_q  <= 3'd0;
            lives_q  <= LIVES_INIT;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            streak_q <= streak_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        misses_d    = misses_q;
        streak_d    = streak_q;
        level_d     = level_q;
        lives_d     = lives_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        char_req    = 1'b0;
        game_over   = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (start) state_d = ARM;
            end
            ARM: begin
                timer_clear = 1'b1;
                char_req    = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                timer_en = 1'b1;
                // A correct key beats a simultaneous expiry.
                if (key_valid && (key_code == target_code)) begin
                    state_d = HIT;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (streak_q + 8'd1 == HPL) begin
                        streak_d = 8'd0;
                        if (level_q < MAXL) level_d = level_q + 3'd1;
                    end else begin
                        streak_d = streak_q + 8'd1;
                    end
                end else if (newTime == 4'd0) begin
                    state_d  = TIMEOUT;
                    streak_d = 8'd0;
                    if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                end else if (key_valid) begin
                    if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
                end
            end
            HIT: begin
                timer_clear = 1'b1;
                state_d     = ARM;
            end
            TIMEOUT: begin
                timer_clear = 1'b1;
                state_d     = (lives_q == 2'd0) ? OVER : ARM;
            end
            OVER: begin
                timer_clear = 1'b1;
                game_over   = 1'b1;
                if (start) begin
                    state_d  = ARM;
                    score_d  = 8'd0;
                    misses_d = 8'd0;
                    streak_d = 8'd0;
                    level_d  = 3'd0;
                    lives_d  = LIVES_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clamp at zero before applying the floor so high levels never underflow.
    logic [3:0] lvl4, diff;
    always_comb begin
        lvl4          = {1'b0, level_q};
        diff          = (lvl4 >= BASE4) ? 4'd0 : (BASE4 - lvl4);
        currTimeLimit = (diff < MIN4) ? MIN4 : diff;
    end

    assign score  = score_q;
    assign misses = misses_q;
    assign level  = level_q;
    assign lives  = lives_q;
    assign state  = state_q;

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Vector-table bench for typing_round_ctrl with an expectation queue checked one cycle after each drive.
module tb_typing_round_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2,
                           S_HIT = 3'd3, S_TO = 3'd4, S_OVER = 3'd5;

    logic       clk, reset, start, key_valid;
    logic [7:0] key_code, target_code;
    logic [3:0] newTime;
    logic       timer_clear, timer_en, char_req, game_over;
    logic [3:0] currTimeLimit;
    logic [7:0] score, misses;
    logic [2:0] level, state;
    logic [1:0] lives;

    typedef struct {
        logic       rst_n, st, kv;
        logic [7:0] kc;
        logic [3:0] nt;
        logic [2:0] e_state;
        logic [7:0] e_score, e_miss;
        logic [2:0] e_lvl;
        logic [1:0] e_lives;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    typing_round_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .key_valid(key_valid),
        .key_code(key_code), .target_code(target_code), .newTime(newTime),
        .timer_clear(timer_clear), .timer_en(timer_en), .currTimeLimit(currTimeLimit),
        .char_req(char_req), .score(score), .misses(misses), .level(level),
        .lives(lives), .game_over(game_over), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic kv, input logic [7:0] kc,
                       input logic [3:0] nt, input logic [2:0] es, input int sc, input int mi,
                       input int lv, input int li);
        vec_t v;
        v.rst_n = r; v.st = s; v.kv = kv; v.kc = kc; v.nt = nt; v.e_state = es;
        v.e_score = 8'(sc); v.e_miss = 8'(mi); v.e_lvl = 3'(lv); v.e_lives = 2'(li);
        tbl.push_back(v);
    endtask

    // One full successful round starting in RUN: HIT, ARM, back to RUN.
    task automatic hit_round(input int sc, input int mi, input int lv, input int li);
        add(1, 0, 1, 8'h41, 4'd5, S_HIT, sc, mi, lv, li);
        add(1, 0, 0, 8'h00, 4'd5, S_ARM, sc, mi, lv, li);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN, sc, mi, lv, li);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    function automatic int lim_of(input int lv);
        return (10 - lv < 3) ? 3 : 10 - lv;
    endfunction

    initial begin
        vec_t e;
        logic [3:0] mo;
        int h;
        reset = 1'b0; start = 1'b0; key_valid = 1'b0; key_code = 8'h00;
        target_code = 8'h41; newTime = 4'd5;

        // Reset held with active start/key/expiry, then a plain start.
        add(0, 1, 1, 8'h41, 4'd0, S_IDLE, 0, 0, 0, 3);
        add(0, 1, 1, 8'h41, 4'd0, S_IDLE, 0, 0, 0, 3);
        add(1, 0, 0, 8'h00, 4'd5, S_IDLE, 0, 0, 0, 3);
        add(1, 1, 0, 8'h00, 4'd5, S_ARM,  0, 0, 0, 3);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN,  0, 0, 0, 3);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN,  0, 0, 0, 3);
        for (int k = 1; k <= 4; k++) hit_round(k, 0, 0, 3);
        // Mid-RUN reset with a matching key; then a stray key in IDLE.
        add(0, 0, 1, 8'h41, 4'd0, S_IDLE, 0, 0, 0, 3);
        add(1, 0, 1, 8'h42, 4'd5, S_IDLE, 0, 0, 0, 3);
        // Start held through ARM and RUN is ignored there.
        add(1, 1, 0, 8'h00, 4'd5, S_ARM,  0, 0, 0, 3);
        add(1, 1, 0, 8'h00, 4'd5, S_RUN,  0, 0, 0, 3);
        add(1, 1, 0, 8'h00, 4'd5, S_RUN,  0, 0, 0, 3);
        for (int k = 1; k <= 5; k++) hit_round(k, 0, k / 5, 3);
        add(1, 0, 1, 8'h42, 4'd5, S_RUN,  5, 1, 1, 3);
        // Streak must clear on timeout: 2 hits + timeout + 3 hits stays level 1.
        hit_round(6, 1, 1, 3);
        hit_round(7, 1, 1, 3);
        add(1, 0, 0, 8'h00, 4'd0, S_TO,   7, 1, 1, 2);
        add(1, 0, 0, 8'h00, 4'd0, S_ARM,  7, 1, 1, 2);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN,  7, 1, 1, 2);
        for (int k = 8; k <= 10; k++) hit_round(k, 1, 1, 2);
        add(1, 0, 0, 8'h00, 4'd0, S_TO,   10, 1, 1, 1);
        add(1, 0, 0, 8'h00, 4'd5, S_ARM,  10, 1, 1, 1);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN,  10, 1, 1, 1);
        add(1, 0, 0, 8'h00, 4'd0, S_TO,   10, 1, 1, 0);
        add(1, 0, 0, 8'h00, 4'd0, S_OVER, 10, 1, 1, 0);
        add(1, 0, 1, 8'h41, 4'd0, S_OVER, 10, 1, 1, 0);
        add(1, 1, 0, 8'h00, 4'd5, S_ARM,  0, 0, 0, 3);
        add(1, 0, 0, 8'h00, 4'd5, S_RUN,  0, 0, 0, 3);
        // Matching key with expiry resolves as a hit; keys in HIT/ARM are ignored.
        add(1, 0, 1, 8'h41, 4'd0, S_HIT,  1, 0, 0, 3);
        add(1, 0, 1, 8'h41, 4'd5, S_ARM,  1, 0, 0, 3);
        add(1, 0, 1, 8'h42, 4'd5, S_RUN,  1, 0, 0, 3);
        // Level and time-limit saturation, then misses saturation.
        for (int k = 1; k <= 40; k++) begin
            h = 1 + k;
            hit_round(h, 0, (h / 5 > 7) ? 7 : h / 5, 3);
        end
        for (int m = 1; m <= 300; m++)
            add(1, 0, 1, 8'h42, 4'd5, S_RUN, 41, (m > 255) ? 255 : m, 7, 3);
        add(0, 0, 0, 8'h00, 4'd5, S_IDLE, 0, 0, 0, 3);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst_n; start = tbl[i].st; key_valid = tbl[i].kv;
            key_code = tbl[i].kc; newTime = tbl[i].nt;
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            case (e.e_state)
                S_ARM:   mo = 4'b1100;
                S_RUN:   mo = 4'b0010;
                S_OVER:  mo = 4'b0101;
                default: mo = 4'b0100;
            endcase
            chk("state",     i, {5'd0, state},         {5'd0, e.e_state});
            chk("score",     i, score,                 e.e_score);
            chk("misses",    i, misses,                e.e_miss);
            chk("level",     i, {5'd0, level},         {5'd0, e.e_lvl});
            chk("lives",     i, {6'd0, lives},         {6'd0, e.e_lives});
            chk("limit",     i, {4'd0, currTimeLimit}, 8'(lim_of(int'(e.e_lvl))));
            chk("char_req",  i, {7'd0, char_req},      {7'd0, mo[3]});
            chk("clear",     i, {7'd0, timer_clear},   {7'd0, mo[2]});
            chk("timer_en",  i, {7'd0, timer_en},      {7'd0, mo[1]});
            chk("game_over", i, {7'd0, game_over},     {7'd0, mo[0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
